// File: rtl/qq_pkg.sv
// qq_pkg: shared state encoding, default widths and sentinel helper for the fill sequencer.
package qq_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_FILL, ST_WAIT_DONE, ST_RUN, ST_DRAIN
  } qq_fill_state_t;
  localparam int KEY_W_DEF  = 8;
  localparam int DATA_W_DEF = 16;
  function automatic logic [63:0] sentinel_key(input int w);
    return (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
  endfunction
endpackage

// File: rtl/qq_reg_slice.sv
// qq_reg_slice: one-entry register slice; push/pop are pre-qualified handshakes from the owner.
module qq_reg_slice #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic [W-1:0] data_o
);
  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;
  always_comb begin
    full_d = push_i ? 1'b1 : (pop_i ? 1'b0 : full_q);
    data_d = push_i ? data_i : data_q;
  end
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end
  assign full_o = full_q;
  assign data_o = data_q;
endmodule

// File: rtl/qq_fill_seq.sv
// qq_fill_seq: start-up sequencer that seeds the queue with sentinel entries,
// then forwards upstream enqueues through a one-entry slice.
module qq_fill_seq
  import qq_pkg::*;
#(
  parameter int KEY_W   = KEY_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int FILL_N  = 3,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [KEY_W-1:0]  in_key,
  input  logic [DATA_W-1:0] in_data,
  output logic              enq_valid,
  input  logic              enq_ready,
  output logic [KEY_W-1:0]  enq_key,
  output logic [DATA_W-1:0] enq_data,
  output logic              cnt_clr,
  output logic              fill_cnt,
  input  logic              cnt_done,
  output logic              busy,
  output logic              run,
  output logic              fill_err
);
  localparam int IW = $clog2(FILL_N + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(FILL_N - 1);
  localparam logic [TW-1:0] LAST_TO  = TW'(TIMEOUT - 1);
  qq_fill_state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] to_q, to_d;
  logic          err_q, err_d;
  logic                     sl_full;
  logic [KEY_W+DATA_W-1:0]  sl_data;
  // The slice only ever holds data in RUN/DRAIN, so its full flag alone qualifies pop.
  qq_reg_slice #(.W(KEY_W + DATA_W)) u_slice (
    .clk    (clk),
    .clr_n  (rst),
    .push_i (in_valid && in_ready),
    .pop_i  (sl_full && enq_ready),
    .data_i ({in_key, in_data}),
    .full_o (sl_full),
    .data_o (sl_data)
  );
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    to_d      = to_q;
    err_d     = err_q;
    cnt_clr   = 1'b0;
    fill_cnt  = 1'b0;
    enq_valid = 1'b0;
    enq_key   = '0;
    enq_data  = '0;
    in_ready  = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_CLEAR;
        err_d   = 1'b0;
      end
      ST_CLEAR: begin
        cnt_clr = 1'b1;
        idx_d   = '0;
        to_d    = '0;
        state_d = ST_FILL;
      end
      ST_FILL: begin
        enq_valid = 1'b1;
        enq_key   = KEY_W'(sentinel_key(KEY_W));
        fill_cnt  = enq_ready;
        if (cnt_done) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (enq_ready) begin
          idx_d   = idx_q + IW'(1);
          state_d = (idx_q == LAST_IDX) ? ST_WAIT_DONE : ST_FILL;
        end
      end
      ST_WAIT_DONE: if (cnt_done) state_d = ST_RUN;
      else begin
        to_d = to_q + TW'(1);
        if (to_q == LAST_TO) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        in_ready  = !start && (!sl_full || enq_ready);
        enq_valid = sl_full;
        {enq_key, enq_data} = sl_data;
        if (start) state_d = (sl_full && !enq_ready) ? ST_DRAIN : ST_CLEAR;
      end
      ST_DRAIN: begin
        enq_valid = sl_full;
        {enq_key, enq_data} = sl_data;
        if (!sl_full || enq_ready) state_d = ST_CLEAR;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      to_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end
  assign busy     = (state_q == ST_CLEAR) || (state_q == ST_FILL) ||
                    (state_q == ST_WAIT_DONE) || (state_q == ST_DRAIN);
  assign run      = (state_q == ST_RUN);
  assign fill_err = err_q;
endmodule

// File: doc/qq_fill_seq.md
Name: qq_fill_seq

Overview:
Start-up fill sequencer for the Quick Priority Queue. On start it clears the external fill counter and enqueues FILL_N sentinel entries into the queue, pulsing fill_cnt once per accepted entry. It then waits for cnt_done and switches to RUN, where upstream enqueue traffic passes to the queue through a one-entry register slice. It cross-checks its own fill count against cnt_done and flags any mismatch.

Parameters:
KEY_W, 8, key width; sentinel key is all-ones (lowest priority).
DATA_W, 16, payload width; sentinel payload is 0.
FILL_N, 3, number of sentinel entries per fill; legal range 1..255.
TIMEOUT, 15, maximum cycles in WAIT_DONE before an error is flagged.

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-low.
start  in  1  single-cycle request to begin or restart a fill.
in_valid  in  1  upstream entry valid.
in_ready  out  1  upstream entry accepted when in_valid and in_ready are both high.
in_key  in  KEY_W  upstream key.
in_data  in  DATA_W  upstream payload.
enq_valid  out  1  enqueue to the queue is valid.
enq_ready  in  1  queue accepts the enqueue.
enq_key  out  KEY_W  enqueue key.
enq_data  out  DATA_W  enqueue payload.
cnt_clr  out  1  synchronous clear to the fill counter.
fill_cnt  out  1  one pulse per sentinel accepted by the queue.
cnt_done  in  1  fill counter complete.
busy  out  1  high in CLEAR, FILL, WAIT_DONE and DRAIN.
run  out  1  high in RUN only.
fill_err  out  1  sticky error flag.

Behaviour:
- Reset (rst low, async): state IDLE, fill index 0, timeout counter 0, slice empty, fill_err 0. All outputs 0, including in_ready and enq_valid.
- States: IDLE, CLEAR, FILL, WAIT_DONE, RUN, DRAIN. State is held in registers. Outputs are decoded from state, plus the handshake terms defined below.
- IDLE: start moves to CLEAR and clears fill_err in the same edge.
- CLEAR: exactly 1 cycle with cnt_clr=1. The fill index and timeout counter are cleared. Next state is FILL.
- FILL:
  - Drives enq_valid=1, enq_key=all-ones, enq_data=0.
  - fill_cnt = enq_ready, i.e. asserted in the same cycle as the accepted handshake; never asserted otherwise.
  - The index increments on each handshake. The handshake at index FILL_N-1 moves to WAIT_DONE.
  - enq_valid stays high with stable key/data until accepted.
- WAIT_DONE:
  - enq_valid=0. cnt_done=1 moves to RUN.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT, set fill_err and go to IDLE.
- Early done: cnt_done=1 while in FILL sets fill_err and aborts to IDLE in the next cycle. This takes priority over the handshake; fill_cnt still follows enq_ready in that cycle.
- RUN:
  - run=1. The slice is a one-entry valid/ready register.
  - in_ready = !slice_full || enq_ready.
  - enq_valid = slice_full; enq_key and enq_data come from the slice.
  - Latency from in handshake to enq_valid is 1 cycle. Full throughput when enq_ready stays high. No combinational path from in_valid to enq_valid.
- start in RUN: in_ready drops to 0 combinationally in that cycle, so no new entry is accepted. Next state:
  - DRAIN if the slice is full and not emptying this cycle;
  - otherwise CLEAR.
- DRAIN: in_ready=0. The slice drains via enq_ready, then the block moves to CLEAR. No entry is lost or duplicated.
- start is ignored in CLEAR, FILL, WAIT_DONE and DRAIN.
- fill_err: set only by timeout or early done; cleared only by start accepted in IDLE, or by reset.
- Reset mid-operation: everything returns to reset values at once, and any in-flight slice entry is discarded.
- Widths: the fill index is $clog2(FILL_N+1) bits; the timeout counter is $clog2(TIMEOUT+1) bits. Neither counter wraps.

Decomposition:
- Package qq_pkg holds:
  - the state enum qq_fill_state_t;
  - the default KEY_W and DATA_W constants;
  - a sentinel_key function returning all-ones for a given width.
- Sub-module qq_reg_slice: a one-entry valid/ready register of width KEY_W+DATA_W, with a clear input driven by reset. qq_fill_seq instantiates it for the RUN and DRAIN path.

Test Plan:
- Nominal fill, FILL_N=3, enq_ready tied high, cnt_done raised 1 cycle after the third fill_cnt:
  - start gives cnt_clr for 1 cycle, then 3 consecutive fill_cnt pulses with enq_key=0xFF and enq_data=0;
  - run=1 on the cycle after cnt_done; busy low from then on.
- Backpressure in FILL, enq_ready pattern 0,1,0,0,1,1: fill_cnt fires only on ready cycles (exactly 3); enq_key/enq_data stay stable while stalled.
- Timeout, TIMEOUT=15, cnt_done never asserted: fill_err=1 exactly 15 cycles after entering WAIT_DONE; state IDLE; the next start clears fill_err.
- Early done, cnt_done=1 after the first fill_cnt: fill_err=1 and IDLE on the next cycle; no further fill_cnt pulses.
- RUN streaming: keys 0x10, 0x20, 0x30 presented back-to-back with enq_ready high appear on enq_key 1 cycle later in order. With enq_ready held low, in_ready drops after the first entry and the second entry is held upstream.
- Restart with slice full and enq_ready low, then start: DRAIN with in_ready=0. When enq_ready rises, the held entry is delivered once, then cnt_clr fires. Asserting rst low mid-FILL zeroes all outputs immediately.
